up_master: RTL and testbench



---
 rtl/up_master.sv | 179 +++++++++++++++++
 tb/tb_up_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_master.sv
// up_master: single-outstanding register-bus initiator for the CPU-side up_* port.
// Accepts one read/write command on a valid/ready port, runs one up_cs/up_wr/up_rd
// transaction, waits out up_busy, and returns the result on a valid/ready port.
// Optional feature macro: UP_MASTER_TIMEOUT_EN (enables the WAIT timeout/abort path).
module up_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              up_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              up_cs,
  output logic              up_wr,
  output logic              up_rd,
  output logic [ADDR_W-1:0] up_addr,
  output logic [DATA_W-1:0] up_data_wr,
  input  logic [DATA_W-1:0] up_data_rd,
  input  logic              up_busy
);

  localparam int unsigned WCW = $clog2(TIMEOUT_CYC);
`ifdef UP_MASTER_TIMEOUT_EN
  localparam logic [WCW-1:0] W_CNT_LAST = WCW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RSP
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WCW-1:0]    r_wait_cnt;
  logic [WCW-1:0]    w_wait_cnt;
  logic              r_cmd_wr;
  logic              w_cmd_wr;
  logic              r_up_cs;
  logic              w_up_cs;
  logic              r_up_wr;
  logic              w_up_wr;
  logic              r_up_rd;
  logic              w_up_rd;
  logic [ADDR_W-1:0] r_up_addr;
  logic [ADDR_W-1:0] w_up_addr;
  logic [DATA_W-1:0] r_up_data_wr;
  logic [DATA_W-1:0] w_up_data_wr;
  logic              r_rsp_valid;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              r_rsp_err;
  logic              w_rsp_err;

  // State and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge up_clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_cmd_wr     <= 1'b0;
      r_up_cs      <= 1'b0;
      r_up_wr      <= 1'b0;
      r_up_rd      <= 1'b0;
      r_up_addr    <= '0;
      r_up_data_wr <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wait_cnt   <= w_wait_cnt;
      r_cmd_wr     <= w_cmd_wr;
      r_up_cs      <= w_up_cs;
      r_up_wr      <= w_up_wr;
      r_up_rd      <= w_up_rd;
      r_up_addr    <= w_up_addr;
      r_up_data_wr <= w_up_data_wr;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_rdata  <= w_rsp_rdata;
      r_rsp_err    <= w_rsp_err;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead so
  // every up_*/rsp_* output comes straight from a flop.
  always_comb begin
    w_next_state = r_state;
    w_wait_cnt   = r_wait_cnt;
    w_cmd_wr     = r_cmd_wr;
    w_up_cs      = r_up_cs;
    w_up_wr      = 1'b0;
    w_up_rd      = 1'b0;
    w_up_addr    = r_up_addr;
    w_up_data_wr = r_up_data_wr;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_rdata  = r_rsp_rdata;
    w_rsp_err    = r_rsp_err;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next_state = S_STROBE;
          w_cmd_wr     = cmd_wr;
          w_up_cs      = 1'b1;
          w_up_wr      = cmd_wr;
          w_up_rd      = !cmd_wr;
          w_up_addr    = cmd_addr;
          w_up_data_wr = cmd_wdata;
        end
      end

      S_STROBE: begin
        w_next_state = S_WAIT;
        w_wait_cnt   = '0;
      end

      S_WAIT: begin
`ifdef UP_MASTER_TIMEOUT_EN
        if (r_wait_cnt != W_CNT_LAST) begin
          w_wait_cnt = r_wait_cnt + WCW'(1);
        end
`else
        if (r_wait_cnt == '0) begin
          w_wait_cnt = WCW'(1);
        end
`endif
        // First WAIT cycle (count 0) gives the target time to raise up_busy.
        if ((r_wait_cnt != '0) && !up_busy) begin
          w_next_state = S_RSP;
          w_up_cs      = 1'b0;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = r_cmd_wr ? '0 : up_data_rd;
          w_rsp_err    = 1'b0;
        end
`ifdef UP_MASTER_TIMEOUT_EN
        else if (r_wait_cnt == W_CNT_LAST) begin
          w_next_state = S_RSP;
          w_up_cs      = 1'b0;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = '0;
          w_rsp_err    = 1'b1;
        end
`endif
      end

      S_RSP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
          w_rsp_valid  = 1'b0;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign up_cs      = r_up_cs;
  assign up_wr      = r_up_wr;
  assign up_rd      = r_up_rd;
  assign up_addr    = r_up_addr;
  assign up_data_wr = r_up_data_wr;

endmodule

// File: tb/tb_up_master.sv
// Testbench for up_master: directed command sequence with a response scoreboard.
module tb_up_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          up_clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          up_cs;
  logic          up_wr;
  logic          up_rd;
  logic [AW-1:0] up_addr;
  logic [DW-1:0] up_data_wr;
  logic [DW-1:0] up_data_rd = '0;
  logic          up_busy = 1'b0;

  up_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .up_clk(up_clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .up_cs(up_cs),
    .up_wr(up_wr),
    .up_rd(up_rd),
    .up_addr(up_addr),
    .up_data_wr(up_data_wr),
    .up_data_rd(up_data_rd),
    .up_busy(up_busy)
  );

  always #5 up_clk = ~up_clk;

  int cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            t_rsp;   // expected cycle of first rsp_valid; -1 = not timed
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge up_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] rd, input logic err, input int t);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.t_rsp = t;
    sb.push_back(e);
  endtask

  // Presents a command and returns the cycle in which it was accepted.
  task automatic do_cmd(input string tag, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int t);
    logic acc;
    acc       = 1'b0;
    t         = -1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        acc = 1'b1;
        t   = cyc;
        step();
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk({tag, "_accepted"}, {63'b0, acc}, 64'd1);
  endtask

  // Waits for a response, checks it against the scoreboard head, consumes it.
  task automatic wait_rsp(input string tag);
    logic seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_rsp_seen"}, {63'b0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_sb_has_entry"}, {63'b0, (sb.size() != 0)}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.t_rsp >= 0) chk({tag, "_rsp_cycle"}, 64'(cyc), 64'(e.t_rsp));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        chk({tag, "_err"}, {63'b0, rsp_err}, {63'b0, e.err});
        chk({tag, "_cs_low"}, {63'b0, up_cs}, 64'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_dropped"}, {63'b0, rsp_valid}, 64'd0);
      chk({tag, "_ready_back"}, {63'b0, cmd_ready}, 64'd1);
    end
  endtask

  initial begin
    int t;
    int r;
    int nseen;

    // Reset, with a command presented that must not be taken.
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 32'hFFFF_0000;
    cmd_wdata = 32'h5555_AAAA;
    step(); step(); step();
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_up_cs", {63'b0, up_cs}, 64'd0);
    chk("rst_up_wr", {63'b0, up_wr}, 64'd0);
    chk("rst_up_rd", {63'b0, up_rd}, 64'd0);
    chk("rst_up_addr", 64'(up_addr), 64'd0);
    chk("rst_up_data_wr", 64'(up_data_wr), 64'd0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_idle_cs", {63'b0, up_cs}, 64'd0);

    // Zero-wait write.
    up_busy = 1'b0;
    do_cmd("wr0", 1'b1, 32'h0000_0010, 32'hA5A5_0001, t);
    push('0, 1'b0, t + 4);
    chk("wr0_t1_wr", {63'b0, up_wr}, 64'd1);
    chk("wr0_t1_rd", {63'b0, up_rd}, 64'd0);
    chk("wr0_t1_cs", {63'b0, up_cs}, 64'd1);
    chk("wr0_t1_addr", 64'(up_addr), 64'h10);
    chk("wr0_t1_data", 64'(up_data_wr), 64'hA5A5_0001);
    step();
    chk("wr0_t2_wr", {63'b0, up_wr}, 64'd0);
    chk("wr0_t2_cs", {63'b0, up_cs}, 64'd1);
    chk("wr0_t2_addr", 64'(up_addr), 64'h10);
    chk("wr0_t2_data", 64'(up_data_wr), 64'hA5A5_0001);
    step();
    chk("wr0_t3_cs", {63'b0, up_cs}, 64'd1);
    chk("wr0_t3_addr", 64'(up_addr), 64'h10);
    chk("wr0_t3_data", 64'(up_data_wr), 64'hA5A5_0001);
    wait_rsp("wr0");

    // Zero-wait read.
    up_data_rd = 32'h1234_5678;
    do_cmd("rd0", 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, t);
    push(32'h1234_5678, 1'b0, t + 4);
    chk("rd0_t1_rd", {63'b0, up_rd}, 64'd1);
    chk("rd0_t1_wr", {63'b0, up_wr}, 64'd0);
    chk("rd0_t1_addr", 64'(up_addr), 64'h20);
    step();
    chk("rd0_t2_rd", {63'b0, up_rd}, 64'd0);
    wait_rsp("rd0");

    // Read with busy high T+2..T+7; data valid only from T+8.
    up_data_rd = 32'hDEAD_BEEF;
    do_cmd("rdb", 1'b0, 32'h0000_0030, 32'h0, t);
    push(32'hCAFE_F00D, 1'b0, t + 9);
    step();
    up_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rdb_wait_cs", {63'b0, up_cs}, 64'd1);
      chk("rdb_wait_no_rsp", {63'b0, rsp_valid}, 64'd0);
    end
    step();
    up_busy    = 1'b0;
    up_data_rd = 32'hCAFE_F00D;
    wait_rsp("rdb");

    // Busy only in the first WAIT cycle is ignored.
    up_data_rd = 32'h0BAD_F00D;
    do_cmd("rdi", 1'b0, 32'h0000_0040, 32'h0, t);
    push(32'h0BAD_F00D, 1'b0, t + 4);
    step();
    up_busy = 1'b1;
    step();
    up_busy = 1'b0;
    wait_rsp("rdi");

    // Write with a one-cycle busy-low glitch at T+6 completing it.
    up_data_rd = 32'h9999_9999;
    do_cmd("wrg", 1'b1, 32'h0000_0044, 32'h4444_4444, t);
    push('0, 1'b0, t + 7);
    step();
    up_busy = 1'b1;
    step(); step(); step();
    step();
    up_busy = 1'b0;
    step();
    up_busy = 1'b1;
    wait_rsp("wrg");
    up_busy = 1'b0;

`ifdef UP_MASTER_TIMEOUT_EN
    // Busy stuck high: abort after TIMEOUT_CYC WAIT cycles.
    up_data_rd = 32'h1111_1111;
    do_cmd("tmo", 1'b0, 32'h0000_0050, 32'h0, t);
    push('0, 1'b1, t + 18);
    up_busy = 1'b1;
    wait_rsp("tmo");
    up_busy = 1'b0;
`else
    // Busy stuck high without timeout: no response, transaction held open.
    up_data_rd = 32'h1111_1111;
    do_cmd("hang", 1'b0, 32'h0000_0050, 32'h0, t);
    up_busy = 1'b1;
    nseen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (rsp_valid) nseen++;
    end
    chk("hang_no_rsp", 64'(nseen), 64'd0);
    chk("hang_cs_held", {63'b0, up_cs}, 64'd1);
    up_busy = 1'b0;
    push(32'h1111_1111, 1'b0, cyc + 1);
    wait_rsp("hang");
`endif

    // Two queued commands with the first response held off.
    do_cmd("q1", 1'b1, 32'h0000_0060, 32'h6060_6060, t);
    cmd_wr     = 1'b0;
    cmd_addr   = 32'h0000_0070;
    cmd_wdata  = 32'h7070_7070;
    cmd_valid  = 1'b1;
    up_data_rd = 32'h7777_7777;
    for (int i = 0; i < 13; i++) begin
      chk("q_blocked_ready", {63'b0, cmd_ready}, 64'd0);
      chk("q_rsp_valid", {63'b0, rsp_valid}, {63'b0, (cyc >= t + 4)});
      step();
    end
    push('0, 1'b0, -1);
    wait_rsp("q1");
    r = cyc;
    chk("q2_not_yet_strobed", {63'b0, up_cs}, 64'd0);
    step();
    cmd_valid = 1'b0;
    chk("q2_strobe_rd", {63'b0, up_rd}, 64'd1);
    chk("q2_strobe_addr", 64'(up_addr), 64'h70);
    push(32'h7777_7777, 1'b0, r + 4);
    wait_rsp("q2");

    // Asynchronous reset during a read.
    do_cmd("rr", 1'b0, 32'h0000_0080, 32'h0, t);
    chk("rr_t1_rd", {63'b0, up_rd}, 64'd1);
    step();
    rst = 1'b0;
    #1;
    chk("rr_cs_cleared", {63'b0, up_cs}, 64'd0);
    chk("rr_rd_cleared", {63'b0, up_rd}, 64'd0);
    chk("rr_rsp_cleared", {63'b0, rsp_valid}, 64'd0);
    chk("rr_addr_cleared", 64'(up_addr), 64'd0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0090;
    step(); step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rr_no_accept_in_rst", {63'b0, up_cs}, 64'd0);
    chk("rr_no_stale_rsp", {63'b0, rsp_valid}, 64'd0);
    do_cmd("wra", 1'b1, 32'h0000_00A0, 32'hA0A0_A0A0, t);
    push('0, 1'b0, t + 4);
    chk("wra_t1_data", 64'(up_data_wr), 64'hA0A0_A0A0);
    wait_rsp("wra");

    nseen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) nseen++;
    end
    chk("end_no_extra_rsp", 64'(nseen), 64'd0);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
